// File: rtl/approx_pkg.sv
// approx_pkg
// Shared defaults and FSM encoding for the approximate-multiplier error monitor.
// Holds the default product, counter and accumulator widths and the control
// state type used by approx_err_monitor.
package approx_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;
  localparam int ACC_W_DEF = 48;

  // state | meaning
  // IDLE  | waiting for start; last window's results stay on the outputs
  // ACCUM | accepting samples until WIN have been taken
  // DRAIN | waiting for the two pipeline stages to empty
  // DONE  | result presented until res_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/approx_err_stage.sv
// approx_err_stage
// Combinational error of one sample pair.
//   i_approx_p : approximate product, unsigned
//   i_exact_p  : exact product, unsigned
//   o_d        : exact - approx, WIDTH+1-bit two's complement
//   o_ed       : |exact - approx| (always fits in WIDTH bits)
//   o_neq      : approx != exact
module approx_err_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_approx_p,
  input  logic [WIDTH-1:0] i_exact_p,
  output logic [WIDTH:0]   o_d,
  output logic [WIDTH-1:0] o_ed,
  output logic             o_neq
);

  logic [WIDTH:0] w_neg;

  always_comb begin
    o_d   = {1'b0, i_exact_p} - {1'b0, i_approx_p};
    w_neg = {1'b0, i_approx_p} - {1'b0, i_exact_p};
    o_ed  = o_d[WIDTH] ? w_neg[WIDTH-1:0] : o_d[WIDTH-1:0];
    o_neq = (i_approx_p != i_exact_p);
  end

endmodule

// File: rtl/approx_err_monitor.sv
// approx_err_monitor
// Accumulates error metrics of (approx, exact) product pairs over a window of
// WIN accepted samples and presents them on a result handshake.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : opens a window from IDLE
//   in_valid/in_ready     : sample handshake; approx_p, exact_p are the pair
//   busy                  : start accepted, result not yet taken
//   res_valid/res_ready   : result handshake
//   res_sum_ed, res_bias  : saturating sum of |d| and of (approx-exact)
//   res_max_ed            : largest |d| in the window
//   res_err_cnt           : samples with approx != exact
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WIN   = 1024,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] approx_p,
  input  logic [WIDTH-1:0] exact_p,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_sum_ed,
  output logic [ACC_W-1:0] res_bias,
  output logic [WIDTH-1:0] res_max_ed,
  output logic [CNT_W-1:0] res_err_cnt
);

  localparam logic [ACC_W-1:0] BIAS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] BIAS_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           r_state;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_res_valid;
  logic             r_start_pend;
  logic [CNT_W-1:0] r_remain;

  logic             r_s1_valid;
  logic [WIDTH:0]   r_s1_d;
  logic [WIDTH-1:0] r_s1_ed;
  logic             r_s1_neq;
  logic             r_s2_valid;

  logic [ACC_W-1:0] r_sum;
  logic [ACC_W-1:0] r_bias;
  logic [WIDTH-1:0] r_max;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH:0]   w_d;
  logic [WIDTH-1:0] w_ed;
  logic             w_neq;
  logic             w_accept;
  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W-1:0] w_sum_nxt;
  logic [ACC_W:0]   w_bias_ext;
  logic [ACC_W-1:0] w_bias_nxt;

  approx_err_stage #(.WIDTH(WIDTH)) u_stage (
    .i_approx_p (approx_p),
    .i_exact_p  (exact_p),
    .o_d        (w_d),
    .o_ed       (w_ed),
    .o_neq      (w_neq)
  );

  assign w_accept = (r_state == ACCUM) && r_in_ready && in_valid;

  // One extra bit of headroom; the top bits reveal overflow for the clamp.
  always_comb begin
    w_sum_ext  = {1'b0, r_sum} + (ACC_W+1)'(r_s1_ed);
    w_sum_nxt  = w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];
    w_bias_ext = {r_bias[ACC_W-1], r_bias}
               - {{(ACC_W-WIDTH){r_s1_d[WIDTH]}}, r_s1_d};
    case (w_bias_ext[ACC_W:ACC_W-1])
      2'b01:   w_bias_nxt = BIAS_MAX;
      2'b10:   w_bias_nxt = BIAS_MIN;
      default: w_bias_nxt = w_bias_ext[ACC_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_res_valid  <= 1'b0;
      r_start_pend <= 1'b0;
      r_remain     <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_d       <= '0;
      r_s1_ed      <= '0;
      r_s1_neq     <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_sum        <= '0;
      r_bias       <= '0;
      r_max        <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_d   <= w_d;
        r_s1_ed  <= w_ed;
        r_s1_neq <= w_neq;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum     <= w_sum_nxt;
        r_bias    <= w_bias_nxt;
        if (r_s1_ed > r_max) r_max <= r_s1_ed;
        r_err_cnt <= r_err_cnt + CNT_W'(r_s1_neq);
      end

      case (r_state)
        IDLE: begin
          // The pipeline is empty in IDLE, so clearing here cannot race an update.
          if (start || r_start_pend) begin
            r_state      <= ACCUM;
            r_busy       <= 1'b1;
            r_in_ready   <= 1'b1;
            r_start_pend <= 1'b0;
            r_remain     <= CNT_W'(WIN);
            r_sum        <= '0;
            r_bias       <= '0;
            r_max        <= '0;
            r_err_cnt    <= '0;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_remain <= r_remain - 1'b1;
            if (r_remain == CNT_W'(1)) begin
              r_in_ready <= 1'b0;
              r_state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!r_s1_valid && !r_s2_valid) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state      <= IDLE;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
            // A start coinciding with the hand-off opens the next window from IDLE.
            r_start_pend <= start;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign res_valid   = r_res_valid;
  assign res_sum_ed  = r_sum;
  assign res_bias    = r_bias;
  assign res_max_ed  = r_max;
  assign res_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_approx_err_monitor.sv
module tb_approx_err_monitor;

  typedef struct {
    logic [3:0][31:0] ap;
    logic [3:0][31:0] ex;
    logic [47:0]      sum;
    logic [32:0]      sum33;
    logic [47:0]      bias;
    logic [31:0]      max;
    logic [15:0]      cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, res_ready;
  logic [31:0] approx_p, exact_p;

  logic        a_in_ready, a_busy, a_res_valid;
  logic [47:0] a_sum, a_bias;
  logic [31:0] a_max;
  logic [15:0] a_cnt;
  logic        b_in_ready, b_busy, b_res_valid;
  logic [47:0] b_sum, b_bias;
  logic [31:0] b_max;
  logic [15:0] b_cnt;
  logic        c_in_ready, c_busy, c_res_valid;
  logic [32:0] c_sum, c_bias;
  logic [31:0] c_max;
  logic [15:0] c_cnt;

  vec_t vecs[5];
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  approx_err_monitor #(.WIDTH(32), .WIN(4), .CNT_W(16), .ACC_W(48)) u_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
    .approx_p(approx_p), .exact_p(exact_p), .busy(a_busy), .res_valid(a_res_valid),
    .res_ready(res_ready), .res_sum_ed(a_sum), .res_bias(a_bias), .res_max_ed(a_max),
    .res_err_cnt(a_cnt));

  approx_err_monitor #(.WIDTH(32), .WIN(2), .CNT_W(16), .ACC_W(48)) u_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
    .approx_p(approx_p), .exact_p(exact_p), .busy(b_busy), .res_valid(b_res_valid),
    .res_ready(res_ready), .res_sum_ed(b_sum), .res_bias(b_bias), .res_max_ed(b_max),
    .res_err_cnt(b_cnt));

  approx_err_monitor #(.WIDTH(32), .WIN(4), .CNT_W(16), .ACC_W(33)) u_c (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(c_in_ready),
    .approx_p(approx_p), .exact_p(exact_p), .busy(c_busy), .res_valid(c_res_valid),
    .res_ready(res_ready), .res_sum_ed(c_sum), .res_bias(c_bias), .res_max_ed(c_max),
    .res_err_cnt(c_cnt));

  function automatic vec_t mk(input logic [31:0] a0, e0, a1, e1, a2, e2, a3, e3,
                              input logic [47:0] sum, input logic [32:0] sum33,
                              input logic [47:0] bias, input logic [31:0] max,
                              input logic [15:0] cnt);
    vec_t v;
    v.ap = {a3, a2, a1, a0};
    v.ex = {e3, e2, e1, e0};
    v.sum = sum; v.sum33 = sum33; v.bias = bias; v.max = max; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] a, input logic [31:0] e);
    approx_p = a;
    exact_p  = e;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the edge that accepted the last sample.
  task automatic wait_result(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!a_res_valid && n < 20);
    chk(name, 64'(n), 64'd3);
  endtask

  task automatic release_result;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("handoff_res_valid", 64'(a_res_valid), 64'd0);
    chk("handoff_busy", 64'(a_busy), 64'd0);
  endtask

  task automatic check_vec(input vec_t v);
    chk("sum", 64'(a_sum), 64'(v.sum));
    chk("bias", 64'(a_bias), 64'(v.bias));
    chk("max", 64'(a_max), 64'(v.max));
    chk("err_cnt", 64'(a_cnt), 64'(v.cnt));
    chk("sum33", 64'(c_sum), 64'(v.sum33));
    chk("bias33", 64'(c_bias), 64'(v.bias[32:0]));
  endtask

  task automatic run_vec(input vec_t v, input bit with_start);
    if (with_start) do_start();
    for (int i = 0; i < 4; i++) feed(v.ap[i], v.ex[i]);
    wait_result("latency");
    check_vec(v);
  endtask

  task automatic check_all_zero_a(input string tag);
    chk({tag, "_in_ready"}, 64'(a_in_ready), 64'd0);
    chk({tag, "_busy"}, 64'(a_busy), 64'd0);
    chk({tag, "_res_valid"}, 64'(a_res_valid), 64'd0);
    chk({tag, "_sum"}, 64'(a_sum), 64'd0);
    chk({tag, "_bias"}, 64'(a_bias), 64'd0);
    chk({tag, "_max"}, 64'(a_max), 64'd0);
    chk({tag, "_cnt"}, 64'(a_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int bad;
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    approx_p = '0; exact_p = '0;

    vecs[0] = mk(100, 100, 100, 100, 100, 100, 100, 100,
                 48'd0, 33'd0, 48'd0, 32'd0, 16'd0);
    vecs[1] = mk(10, 12, 15, 12, 7, 7, 0, 5,
                 48'd10, 33'd10, 48'hFFFF_FFFF_FFFC, 32'd5, 16'd3);
    vecs[2] = mk(3, 1, 3, 1, 3, 1, 3, 1,
                 48'd8, 33'd8, 48'd8, 32'd2, 16'd4);
    vecs[3] = mk(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5, 9, 9, 5,
                 48'h2_0000_0006, 33'h1_FFFF_FFFF, 48'd0, 32'hFFFF_FFFF, 16'd4);
    vecs[4] = mk(1, 4, 4, 1, 0, 2, 6, 6,
                 48'd8, 33'd8, 48'hFFFF_FFFF_FFFE, 32'd3, 16'd3);

    tick(); tick();
    check_all_zero_a("rst");
    chk("rst_b_outputs", 64'({b_in_ready, b_busy, b_res_valid, b_sum, b_bias, b_max, b_cnt}), 64'd0);
    chk("rst_c_outputs", 64'({c_in_ready, c_busy, c_res_valid, c_sum, c_bias, c_max, c_cnt}), 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven windows.
    for (int k = 0; k < 5; k++) begin
      run_vec(vecs[k], 1'b1);
      release_result();
    end

    // Full-scale error: WIN=2 exact sums, 33-bit clamps on sum and bias.
    do_start();
    for (int i = 0; i < 4; i++) feed(32'd0, 32'hFFFF_FFFF);
    wait_result("big_latency");
    chk("win2_valid", 64'(b_res_valid), 64'd1);
    chk("win2_sum", 64'(b_sum), 64'h1_FFFF_FFFE);
    chk("win2_bias", 64'(b_bias), 64'hFFFE_0000_0002);
    chk("win2_max", 64'(b_max), 64'hFFFF_FFFF);
    chk("win2_cnt", 64'(b_cnt), 64'd2);
    chk("big_sum48", 64'(a_sum), 64'h3_FFFF_FFFC);
    chk("big_bias48", 64'(a_bias), 64'hFFFC_0000_0004);
    chk("sat_sum33", 64'(c_sum), 64'h1_FFFF_FFFF);
    chk("sat_bias33", 64'(c_bias), 64'h1_0000_0000);
    release_result();

    // in_valid held for 8 samples; only 4 accepted.
    do_start();
    acc = 0;
    for (int i = 1; i <= 8; i++) begin
      approx_p = 32'd0;
      exact_p  = 32'(i);
      in_valid = 1'b1;
      if (a_in_ready) acc++;
      chk($sformatf("in_ready_%0d", i), 64'(a_in_ready), (i <= 4) ? 64'd1 : 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("accepted", 64'(acc), 64'd4);
    n = 0;
    while (!a_res_valid && n < 20) begin
      tick();
      n++;
    end
    chk("ovf_sum", 64'(a_sum), 64'd10);
    chk("ovf_bias", 64'(a_bias), 64'hFFFF_FFFF_FFF6);
    chk("ovf_max", 64'(a_max), 64'd4);
    chk("ovf_cnt", 64'(a_cnt), 64'd4);
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      start = (j % 2 == 0);
      tick();
      if (!a_res_valid || !a_busy || a_sum != 48'd10 || a_max != 32'd4) bad++;
    end
    start = 1'b0;
    chk("hold_stable", 64'(bad), 64'd0);
    release_result();
    tick(); tick();
    chk("done_start_ignored", 64'(a_busy), 64'd0);

    // Reset mid-window discards the partial window.
    do_start();
    feed(32'd0, 32'd1000);
    feed(32'd0, 32'd2000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero_a("midrst");
    run_vec(vecs[2], 1'b1);
    release_result();

    // start on the result hand-off cycle.
    run_vec(vecs[1], 1'b1);
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    chk("b2b_idle_valid", 64'(a_res_valid), 64'd0);
    chk("b2b_idle_busy", 64'(a_busy), 64'd0);
    tick();
    chk("b2b_busy", 64'(a_busy), 64'd1);
    chk("b2b_in_ready", 64'(a_in_ready), 64'd1);
    chk("b2b_cleared", 64'(a_sum), 64'd0);
    run_vec(vecs[4], 1'b0);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
